// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-port arbiter sharing one single-port synchronous RAM,
//             with round-robin or fixed priority and read-data return routing.
//  Revision : 1.0
// ============================================================================
module ram_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fixed_pri_i,
   input  logic [1:0]              req_i,
   input  logic [1:0]              we_i,
   input  logic [2*ADDR_WIDTH-1:0] addr_i,
   input  logic [2*DATA_WIDTH-1:0] wdata_i,
   output logic [1:0]              gnt_o,
   output logic [1:0]              rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    ram_en_o,
   output logic                    ram_wr_rdn_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic [DATA_WIDTH-1:0]   ram_data_wr_o,
   input  logic [DATA_WIDTH-1:0]   ram_data_rd_i
);

   typedef enum logic {
      PTR_P0 = 1'b0,
      PTR_P1 = 1'b1
   } ptr_e;

   ptr_e                  ptr_q,        ptr_d;
   logic [1:0]            gnt_q,        gnt_d;
   logic [1:0]            rvalid_q,     rvalid_d;
   logic                  ram_en_q,     ram_en_d;
   logic                  ram_wr_rdn_q, ram_wr_rdn_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q,   ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_data_q,   ram_data_d;

   logic [1:0]            w_elig;
   logic [1:0]            w_win;
   logic                  w_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q        <= PTR_P0;
         gnt_q        <= 2'b00;
         rvalid_q     <= 2'b00;
         ram_en_q     <= 1'b0;
         ram_wr_rdn_q <= 1'b0;
         ram_addr_q   <= '0;
         ram_data_q   <= '0;
      end else begin
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         rvalid_q     <= rvalid_d;
         ram_en_q     <= ram_en_d;
         ram_wr_rdn_q <= ram_wr_rdn_d;
         ram_addr_q   <= ram_addr_d;
         ram_data_q   <= ram_data_d;
      end
   end

   always_comb begin
      w_elig       = req_i & ~gnt_q;
      w_win        = 2'b00;
      ptr_d        = ptr_q;
      ram_addr_d   = ram_addr_q;
      ram_data_d   = ram_data_q;

      // A port granted last cycle is masked so its held command is not taken twice.
      if (fixed_pri_i || (ptr_q == PTR_P0)) begin
         if (w_elig[0])      w_win = 2'b01;
         else if (w_elig[1]) w_win = 2'b10;
      end else begin
         if (w_elig[1])      w_win = 2'b10;
         else if (w_elig[0]) w_win = 2'b01;
      end

      w_sel        = w_win[1];
      gnt_d        = w_win;
      ram_en_d     = |w_win;
      ram_wr_rdn_d = ram_en_d & we_i[w_sel];

      if (ram_en_d) begin
         ram_addr_d = w_sel ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
         ram_data_d = w_sel ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
         if (!fixed_pri_i) ptr_d = w_sel ? PTR_P0 : PTR_P1;
      end

      // The grant of the command now on the RAM pins names the owner of its read data.
      rvalid_d = {2{ram_en_q & ~ram_wr_rdn_q}} & gnt_q;
   end

   assign gnt_o         = gnt_q;
   assign rvalid_o      = rvalid_q;
   assign rdata_o       = ram_data_rd_i;
   assign ram_en_o      = ram_en_q;
   assign ram_wr_rdn_o  = ram_wr_rdn_q;
   assign ram_addr_o    = ram_addr_q;
   assign ram_data_wr_o = ram_data_q;

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters (port 0, port 1).
- RAM interface: en, wr_rdn, addr, data_wr in; registered data_rd out, valid one cycle after the read command.
- Arbitrates with round-robin or fixed priority and registers the winning command onto the RAM pins.
- Routes read data back to the owning requester with a valid strobe.
- Sits between the CPU-side/DMA-side masters and the RAM.

Parameters:
- data_width, 32, RAM word width.
- addr_width, 10, RAM address width.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fixed_pri  input  1  1 = port 0 always wins; 0 = round-robin.
- req  input  2  per-port request; bit i belongs to port i.
- we  input  2  per-port access type: 1 = write, 0 = read.
- addr  input  2*addr_width  port i address at bits [i*addr_width +: addr_width].
- wdata  input  2*data_width  port i write data at bits [i*data_width +: data_width].
- gnt  output  2  one-cycle accept pulse per port.
- rvalid  output  2  one-cycle read-data-valid pulse per port.
- rdata  output  data_width  read data; qualify with rvalid.
- ram_en  output  1  to RAM en.
- ram_wr_rdn  output  1  to RAM wr_rdn.
- ram_addr  output  addr_width  to RAM addr.
- ram_data_wr  output  data_width  to RAM data_wr.
- ram_data_rd  input  data_width  from RAM data_rd.

Behaviour:
- Reset, asynchronous while rst=1:
  - gnt, rvalid, ram_en, ram_wr_rdn: 0.
  - ram_addr, ram_data_wr: 0.
  - Round-robin pointer: port 0.
  - Read-in-flight tracker: cleared.
- Requester contract:
  - Port i holds req[i], we[i], addr and wdata stable until it sees gnt[i]=1.
  - In the cycle after gnt it may drop the request or present the next one.
- Eligibility at edge N:
  - Port i is eligible when req[i]=1 and gnt[i]=0 in the current cycle.
  - A port whose gnt is high is masked, so the same command is never accepted twice.
- Winner selection, registered at edge N:
  - fixed_pri=1: port 0 wins if eligible, else port 1.
  - fixed_pri=0: the eligible port equal to the pointer wins, else the other eligible port.
  - After any grant under round-robin, the pointer moves to the port that did not win.
  - Under fixed_pri the pointer is unchanged.
- Registered outputs after edge N, valid in cycle N+1:
  - gnt[winner]=1 and ram_en=1.
  - ram_wr_rdn = we[winner]; ram_addr and ram_data_wr = the winner's fields.
  - With no eligible port: gnt=0 and ram_en=0; ram_addr and ram_data_wr keep their last values.
- Read return:
  - The RAM executes the command at edge N+1; for a read, ram_data_rd is valid in cycle N+2.
  - The arbiter records {read_pending, owner} at edge N+1.
  - In cycle N+2, rvalid[owner]=1 (registered) and rdata = ram_data_rd (combinational passthrough).
  - Writes never assert rvalid.
  - Write-to-read at the same address on consecutive grants returns the new data.
- Throughput and latency:
  - One RAM command per cycle maximum.
  - Alternating ports can sustain 100%; one port alone gets one grant every 2 cycles because of the mask.
  - Read latency from the requesting edge to rvalid is 2 cycles.
  - Read pipeline depth is 1; no backpressure on rvalid, and the requester must accept it.
- Simultaneous events:
  - Both ports eligible: the policy above decides and exactly one gnt bit is high.
  - rvalid of one read can coincide with gnt of a later command, for either port.
- Mode change: fixed_pri is sampled each cycle, so a change takes effect on the next arbitration edge.
- Reset mid-operation:
  - An in-flight read is discarded and no rvalid fires after rst deasserts.
  - A command already on the RAM pins is dropped because ram_en goes to 0 immediately.
- At no time: more than one gnt bit high, or rvalid to both ports at once.

Test Plan:
- Reset: assert rst mid-burst with a read in flight -> all outputs 0 immediately; no rvalid in the 3 cycles after release; first grant after release goes to port 0 when both request.
- Single write then read, port 0: write addr 0x005 data 0xDEADBEEF, then read 0x005 -> gnt[0] one cycle after each request; ram_en=1, ram_wr_rdn=1 for the write; rvalid[0]=1 with rdata=0xDEADBEEF exactly 2 cycles after the read request edge.
- Round-robin contention, fixed_pri=0: both ports continuously read (port 0 addr 0x010 = 0x11111111, port 1 addr 0x020 = 0x22222222) -> gnt alternates 01,10,01,...; ram_en high every cycle; rvalid alternates with the matching data.
- Fixed priority, fixed_pri=1, both requesting: port 0 holds req for 6 cycles -> port 1 is granted only in cycles where port 0 is masked (gnt[0] high); no double grant.
- Same-port back-to-back: port 1 issues 4 writes to 0x3FC..0x3FF, then port 0 reads 0x3FF -> port 1 granted every other cycle; the read returns the last value written; address 0x3FF is used with no wrap error.
- Idle hold: req=0 for 5 cycles after a write -> ram_en=0, gnt=0, rvalid=0; ram_addr holds its last value.
